// File: rtl/dvp_pattern_source_if.sv
// DVP camera bus: pixel clock, frame/line syncs and one data byte per pclk.
// Purely combinational bundle; the source side owns every signal and there is no backpressure.
interface dvp_pattern_source_if;
  logic       dvp_pclk;
  logic       dvp_vsync;
  logic       dvp_href;
  logic [7:0] dvp_data;

  modport master (output dvp_pclk, dvp_vsync, dvp_href, dvp_data);
  modport slave  (input  dvp_pclk, dvp_vsync, dvp_href, dvp_data);
endinterface

// File: rtl/dvp_pattern_source.sv
// Synthetic DVP camera: RGB565 test-pattern frames, high byte first, dvp_pclk = clk/2.
// Outputs change one clk after the pclk falling tick; free-running, no backpressure.
module dvp_pattern_source #(
  parameter int IMG_W       = 200,
  parameter int IMG_H       = 162,
  parameter int HBLANK      = 16,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 2,
  parameter int VFP_LINES   = 2,
  parameter bit VSYNC_POL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [1:0]            pattern_sel_i,
  dvp_pattern_source_if.master  dvp,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [7:0]            frame_cnt_o
);

  localparam int L     = 2 * IMG_W + HBLANK;
  localparam int ACT   = 2 * IMG_W;
  localparam int BAR_W = IMG_W / 8;
  localparam int MAXA  = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int MAXB  = (IMG_H > VFP_LINES) ? IMG_H : VFP_LINES;
  localparam int MAXL  = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int CW    = $clog2(L);
  localparam int LW    = $clog2(MAXL + 1);
  localparam int BW    = $clog2(BAR_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  state_t          state_q, state_d;
  logic            ph_q;
  logic [CW-1:0]   col_q, col_d;
  logic [LW-1:0]   line_q, line_d;
  logic [2:0]      bar_q, bar_d;
  logic [BW-1:0]   bpx_q, bpx_d;
  logic [1:0]      sel_q, sel_d;
  logic [5:0]      solid_q, solid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            last_col;
  logic [LW-1:0]   last_line;
  logic [7:0]      cnt_inc;
  logic            href;
  logic [15:0]     pix;
  logic [5:0]      xg;
  logic            x3, y3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q    <= 1'b0;
      state_q <= S_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      bar_q   <= '0;
      bpx_q   <= '0;
      sel_q   <= '0;
      solid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ph_q    <= ~ph_q;
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      bar_q   <= bar_d;
      bpx_q   <= bpx_d;
      sel_q   <= sel_d;
      solid_q <= solid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last_col = (col_q == CW'(L - 1));
  assign cnt_inc  = cnt_q + 8'd1;

  always_comb begin
    last_line = LW'(VFP_LINES - 1);
    case (state_q)
      S_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
      S_VBP:    last_line = LW'(VBP_LINES - 1);
      S_ACTIVE: last_line = LW'(IMG_H - 1);
      default:  last_line = LW'(VFP_LINES - 1);
    endcase
  end

  // Everything advances only on the clk edge where ph falls, i.e. when ph_q is 1.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    bar_d   = bar_q;
    bpx_d   = bpx_q;
    sel_d   = sel_q;
    solid_d = solid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (ph_q) begin
      if (state_q == S_IDLE) begin
        if (en_i) begin
          state_d = S_VSYNC;
          sel_d   = pattern_sel_i;
          solid_d = cnt_q[7:2];
          busy_d  = 1'b1;
          col_d   = '0;
          line_d  = '0;
        end
      end else begin
        col_d = last_col ? '0 : col_q + CW'(1);
        if (state_q == S_ACTIVE && href && col_q[0]) begin
          if (bpx_q == BW'(BAR_W - 1)) begin
            bpx_d = '0;
            bar_d = bar_q + 3'd1;
          end else begin
            bpx_d = bpx_q + BW'(1);
          end
        end
        if (last_col) begin
          bar_d  = '0;
          bpx_d  = '0;
          line_d = line_q + LW'(1);
          if (line_q == last_line) begin
            line_d = '0;
            case (state_q)
              S_VSYNC:  state_d = S_VBP;
              S_VBP:    state_d = S_ACTIVE;
              S_ACTIVE: state_d = S_VFP;
              default: begin
                done_d = 1'b1;
                cnt_d  = cnt_inc;
                if (en_i) begin
                  state_d = S_VSYNC;
                  sel_d   = pattern_sel_i;
                  solid_d = cnt_inc[7:2];
                end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                end
              end
            endcase
          end
        end
      end
    end
  end

  function automatic logic [15:0] grey565(input logic [5:0] v);
    return {v[5:1], v, v[5:1]};
  endfunction

  // Pixel x = col/2, so x[7:2] = col[..:3] and x[3] = col[4].
  assign href = (state_q == S_ACTIVE) && (col_q < CW'(ACT));
  assign xg   = 6'(col_q >> 3);
  assign x3   = col_q[4];
  assign y3   = (32'(line_q) & 32'd8) != 32'd0;

  always_comb begin
    pix = 16'h0000;
    case (sel_q)
      2'd0: begin
        case (bar_q)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = grey565(xg);
      2'd2:    pix = grey565(solid_q);
      default: pix = (x3 ^ y3) ? 16'hFFFF : 16'h0000;
    endcase
  end

  assign dvp.dvp_pclk  = ph_q;
  assign dvp.dvp_vsync = (state_q == S_VSYNC) ? VSYNC_POL : ~VSYNC_POL;
  assign dvp.dvp_href  = href;
  assign dvp.dvp_data  = href ? (col_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
  assign busy_o        = busy_q;
  assign frame_done_o  = done_q;
  assign frame_cnt_o   = cnt_q;

endmodule
